sram_like_responder: RTL and testbench

Slave (responder) end of the SRAM-like bus used by the fetch and memory stages: accepts `req`/`addr_ok` request handshakes, performs word reads/byte-masked writes on an internal word array, and returns `data_ok`/`rdata` in request order after a fixed latency. It serves as the instruction or data memory behind `inst_sram_*`/`data_sram_*` in simulation and FPGA bring-up. It supports multiple outstanding requests, so the pipelined preIF/IF request pattern can be exercised against it.

---
 rtl/sram_like_responder.sv | 99 +++++++++
 tb/tb_sram_like_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sram_like_responder.sv
// SRAM-like bus slave: in-order, fixed-latency responses from a word array.
// Used as inst/data memory for simulation and FPGA bring-up.
module sram_like_responder #(
    parameter int AW      = 12,
    parameter int LAT     = 2,
    parameter int MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_req,
    input  logic        sram_wr,
    input  logic [1:0]  sram_size,
    input  logic [3:0]  sram_wstrb,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic        sram_addr_ok,
    output logic        sram_data_ok,
    output logic [31:0] sram_rdata,
    input  logic        stall_addr
);

    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int TW = 4;

    logic [31:0]   mem [2**AW];
    logic [31:0]   dat_q [MAX_OUT];
    logic [TW-1:0] tmr_q [MAX_OUT];

    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [AW-1:0] idx;
    logic          acc;
    logic          pop;
    logic          unused_ok;

    assign idx = sram_addr[AW+1:2];
    assign unused_ok = ^{sram_size, sram_addr[31:AW+2], sram_addr[1:0]};

    assign sram_addr_ok = resetn && !stall_addr
                       && (cnt_q < CW'(MAX_OUT));
    assign acc = sram_req && sram_addr_ok;

    // Head entry stays queued through its data_ok cycle, so the slot
    // frees only on the following cycle.
    assign pop = (cnt_q != '0) && (tmr_q[rp_q] == '0);

    assign sram_data_ok = resetn && pop;
    assign sram_rdata   = sram_data_ok ? dat_q[rp_q] : 32'h0;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (acc) wp_d = nxt(wp_q);
        if (pop) rp_d = nxt(rp_q);
        if (acc && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!acc && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Read data is captured at accept so it sees all earlier writes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUT; i++) begin
            if (acc && wp_q == PW'(i)) begin
                tmr_q[i] <= TW'(LAT - 1);
                dat_q[i] <= sram_wr ? 32'h0 : mem[idx];
            end else if (tmr_q[i] != '0) begin
                tmr_q[i] <= tmr_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc && sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_wstrb[b]) mem[idx][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// Scoreboard bench: two responders (LAT=2 and LAT=8) sharing the bus
// fields, with separate request lines.
module tb_sram_like_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req [2];
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        aok [2];
    logic        dok [2];
    logic [31:0] rd  [2];
    logic [31:0] exp_d;

    typedef struct {
        logic [31:0] d;
        int          c;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    int   cyc = 0;
    int   chk = 0;
    int   err = 0;

    always #5 clk = ~clk;

    sram_like_responder #(.AW(12), .LAT(2), .MAX_OUT(4)) u_a (
        .clk(clk), .resetn(resetn), .sram_req(req[0]), .sram_wr(wr),
        .sram_size(size), .sram_wstrb(wstrb), .sram_addr(addr),
        .sram_wdata(wdata), .sram_addr_ok(aok[0]), .sram_data_ok(dok[0]),
        .sram_rdata(rd[0]), .stall_addr(stall)
    );

    sram_like_responder #(.AW(12), .LAT(8), .MAX_OUT(4)) u_b (
        .clk(clk), .resetn(resetn), .sram_req(req[1]), .sram_wr(wr),
        .sram_size(size), .sram_wstrb(wstrb), .sram_addr(addr),
        .sram_wdata(wdata), .sram_addr_ok(aok[1]), .sram_data_ok(dok[1]),
        .sram_rdata(rd[1]), .stall_addr(stall)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] want);
        chk++;
        if (act !== want) begin
            err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)",
                     nm, act, want, cyc);
        end
    endtask

    // Push expectations when a request is accepted; flush on reset.
    always @(posedge clk) begin
        if (!resetn) begin
            q0.delete();
            q1.delete();
        end else begin
            if (req[0] && aok[0]) q0.push_back('{d: exp_d, c: cyc + 2});
            if (req[1] && aok[1]) q1.push_back('{d: exp_d, c: cyc + 8});
        end
        cyc++;
    end

    // Monitor: compare every response against the head of its queue.
    always @(negedge clk) begin
        ent_t e;
        #2;
        if (resetn) begin
            if (dok[0]) begin
                if (q0.size() == 0) begin
                    check("a_unexpected_data_ok", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    check("a_rdata", rd[0], e.d);
                    check("a_resp_cycle", cyc, e.c);
                end
            end else begin
                check("a_rdata_idle", rd[0], 32'h0);
                if (q0.size() != 0 && q0[0].c <= cyc) begin
                    e = q0.pop_front();
                    check("a_missed_data_ok", 32'd0, 32'd1);
                end
            end
            if (dok[1]) begin
                if (q1.size() == 0) begin
                    check("b_unexpected_data_ok", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    check("b_rdata", rd[1], e.d);
                    check("b_resp_cycle", cyc, e.c);
                end
            end else if (q1.size() != 0 && q1[0].c <= cyc) begin
                e = q1.pop_front();
                check("b_missed_data_ok", 32'd0, 32'd1);
            end
        end
    end

    task automatic drive(input logic rn, input logic ra, input logic rb,
                         input logic st, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] ex);
        @(negedge clk);
        resetn = rn;
        req[0] = ra;
        req[1] = rb;
        stall  = st;
        wr     = w;
        wstrb  = s;
        addr   = a;
        wdata  = wd;
        exp_d  = ex;
        size   = 2'd2;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        resetn = 0; req[0] = 0; req[1] = 0; wr = 0; size = 0;
        wstrb = 0; addr = 0; wdata = 0; stall = 0; exp_d = 0;

        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            check("rst_addr_ok", {31'b0, aok[0]}, 32'd0);
            check("rst_data_ok", {31'b0, dok[0]}, 32'd0);
            check("rst_rdata", rd[0], 32'h0);
        end

        // First cycle out of reset accepts
        drive(1, 1, 0, 0, 1, 4'hF, 32'h1C00_0000, 32'h1234_5678, 0);
        check("addr_ok_after_reset", {31'b0, aok[0]}, 32'd1);
        drive(1, 1, 0, 0, 0, 0, 32'h1C00_0000, 0, 32'h1234_5678);
        drive(1, 1, 0, 0, 1, 4'b0010, 32'h1C00_0000, 32'h0000_AB00, 0);
        drive(1, 1, 0, 0, 0, 0, 32'h1C00_0000, 0, 32'h1234_AB78);
        drive(1, 1, 0, 0, 0, 0, 32'h1C00_4000, 0, 32'h1234_AB78);

        // Preload both memories
        for (int i = 0; i < 4; i++)
            drive(1, 1, 1, 0, 1, 4'hF, 32'h100 + 4 * i,
                  32'hA0A0_0001 + i, 0);
        idle(2);

        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 0, 0, 32'h100 + 4 * i, 0, 32'hA0A0_0001 + i);
            check("burst_addr_ok", {31'b0, aok[0]}, 32'd1);
        end
        idle(1);

        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 1, 0, 0, 32'h100, 0, 32'hA0A0_0001);
            check("stall_addr_ok", {31'b0, aok[0]}, 32'd0);
        end
        drive(1, 1, 0, 0, 0, 0, 32'h100, 0, 32'hA0A0_0001);
        check("unstall_addr_ok", {31'b0, aok[0]}, 32'd1);
        idle(14);

        // LAT=8: fills after 4 accepts, frees the cycle after first pop
        for (int t = 0; t < 10; t++) begin
            if (t < 4)
                drive(1, 0, 1, 0, 0, 0, 32'h100 + 4 * t, 0,
                      32'hA0A0_0001 + t);
            else
                drive(1, 0, 1, 0, 0, 0, 32'h100, 0, 32'hA0A0_0001);
            check($sformatf("full_addr_ok_t%0d", t), {31'b0, aok[1]},
                  (t < 4 || t == 9) ? 32'd1 : 32'd0);
        end
        idle(14);

        // Reset with two reads in flight
        drive(1, 1, 0, 0, 0, 0, 32'h100, 0, 32'hA0A0_0001);
        drive(1, 1, 0, 0, 0, 0, 32'h104, 0, 32'hA0A0_0002);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("midrst_data_ok", {31'b0, dok[0]}, 32'd0);
        check("midrst_addr_ok", {31'b0, aok[0]}, 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("post_rst_addr_ok", {31'b0, aok[0]}, 32'd1);
        idle(5);
        drive(1, 1, 0, 0, 0, 0, 32'h1C00_0000, 0, 32'h1234_AB78);
        drive(1, 1, 0, 0, 0, 0, 32'h10C, 0, 32'hA0A0_0004);
        idle(5);

        check("a_queue_drained", q0.size(), 32'd0);
        check("b_queue_drained", q1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

endmodule
